food_spawner: RTL

//  Multi-slot food manager for the snake game; parametrised successor of the single-food generator.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/food_lfsr.sv | 18 +
 rtl/food_spawner.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game food logic.
// Optional feature macro: FOOD_ERASE_EN (adds the ERASE state for old-food erasure).
package snake_pkg;

  localparam int X_W_DEF   = 8;
  localparam int Y_W_DEF   = 7;
  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;

  localparam int          LFSR_W    = 16;
  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_CHECK,
    ST_PLOT
`ifdef FOOD_ERASE_EN
    , ST_ERASE
`endif
  } state_t;

  // One step of the 16-bit Galois LFSR; a non-zero value never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/food_lfsr.sv
// Free-running 16-bit Galois LFSR; loads the seed on reset, steps every clock.
module food_lfsr
  import snake_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  // Advance the generator once per clock.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) value <= seed;
    else       value <= lfsr_next(value);
  end

endmodule

// File: rtl/food_spawner.sv
// Multi-slot food manager: collision detection, random respawn, req/ack plotting.
// Optional feature macro: FOOD_ERASE_EN -- erase an eaten item's old cell before respawning it.
module food_spawner
  import snake_pkg::*;
#(
  parameter int          NUM_FOOD  = 4,
  parameter int          X_W       = X_W_DEF,
  parameter int          Y_W       = Y_W_DEF,
  parameter int          X_MAX     = X_MAX_DEF,
  parameter int          Y_MAX     = Y_MAX_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [X_W-1:0]          head_x,
  input  logic [Y_W-1:0]          head_y,
  input  logic                    check_collision,
  output logic [NUM_FOOD-1:0]     food_valid,
  output logic [NUM_FOOD*X_W-1:0] food_x,
  output logic [NUM_FOOD*Y_W-1:0] food_y,
  output logic                    eaten,
  output logic [2:0]              eaten_idx,
  output logic                    plot_req,
  input  logic                    plot_ack,
  output logic [X_W-1:0]          plot_x,
  output logic [Y_W-1:0]          plot_y,
  output logic                    plot_erase,
  output logic                    busy
);

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  state_t              state_q, state_d;
  logic [2:0]          tgt_q, tgt_d;
  logic [X_W-1:0]      slot_x [NUM_FOOD];
  logic [Y_W-1:0]      slot_y [NUM_FOOD];
  logic [NUM_FOOD-1:0] valid_q;
  logic [X_W-1:0]      cand_x;
  logic [Y_W-1:0]      cand_y;
  logic [LFSR_W-1:0]   lfsr;

  logic       hit_any, free_any, cand_ok;
  logic [2:0] hit_idx, free_idx;
  logic       cand_load, slot_write, set_valid;

`ifdef FOOD_ERASE_EN
  logic [NUM_FOOD-1:0] erase_pend;
  logic                pend_any, erase_done;
  logic [2:0]          pend_idx;
`endif

  food_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .value (lfsr)
  );

  // Top LFSR bits beyond the candidate fields are intentionally unused.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr[LFSR_W-1:X_W+Y_W];

  // Lowest-index live slot under the head, lowest empty slot, and candidate legality.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    cand_ok  = (cand_x <= X_LIM) && (cand_y <= Y_LIM) &&
               !((cand_x == head_x) && (cand_y == head_y));
    // Descending scan so the lowest matching index is the last one written.
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (valid_q[i] && (slot_x[i] == head_x) && (slot_y[i] == head_y)) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = 3'(i);
      end
      if (valid_q[i] && (slot_x[i] == cand_x) && (slot_y[i] == cand_y))
        cand_ok = 1'b0;
    end
  end

`ifdef FOOD_ERASE_EN
  // Lowest slot still waiting for its old cell to be erased.
  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (erase_pend[i]) begin
        pend_any = 1'b1;
        pend_idx = 3'(i);
      end
    end
  end
`endif

  // State and target-slot registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    tgt_d      = tgt_q;
    cand_load  = 1'b0;
    slot_write = 1'b0;
    set_valid  = 1'b0;
    plot_req   = 1'b0;
`ifdef FOOD_ERASE_EN
    plot_erase = 1'b0;
    erase_done = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef FOOD_ERASE_EN
        if (pend_any) begin
          tgt_d   = pend_idx;
          state_d = ST_ERASE;
        end else
`endif
        if (free_any) begin
          tgt_d   = free_idx;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        cand_load = 1'b1;
        state_d   = ST_CHECK;
      end
      ST_CHECK: begin
        if (cand_ok) begin
          slot_write = 1'b1;
          state_d    = ST_PLOT;
        end else begin
          // Retry: fetch the next LFSR value in this same cycle so a reject costs one cycle.
          cand_load = 1'b1;
        end
      end
      ST_PLOT: begin
        plot_req = 1'b1;
        if (plot_ack) begin
          set_valid = 1'b1;
          state_d   = ST_IDLE;
        end
      end
`ifdef FOOD_ERASE_EN
      ST_ERASE: begin
        plot_req   = 1'b1;
        plot_erase = 1'b1;
        if (plot_ack) begin
          erase_done = 1'b1;
          state_d    = ST_GEN;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef FOOD_ERASE_EN
  assign plot_erase = 1'b0;
`endif

  // Slot storage, candidate capture and collision reporting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_x    <= '0;
      cand_y    <= '0;
      valid_q   <= '0;
      eaten     <= 1'b0;
      eaten_idx <= '0;
      // NOTE: the slot array is reset because its contents are visible on food_x/food_y.
      for (int i = 0; i < NUM_FOOD; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
`ifdef FOOD_ERASE_EN
      erase_pend <= '0;
`endif
    end else begin
      eaten <= 1'b0;
      if (cand_load) begin
        cand_x <= lfsr[X_W-1:0];
        cand_y <= lfsr[X_W +: Y_W];
      end
      if (check_collision && hit_any) begin
        eaten     <= 1'b1;
        eaten_idx <= hit_idx;
      end
      for (int i = 0; i < NUM_FOOD; i++) begin
        if (slot_write && (tgt_q == 3'(i))) begin
          slot_x[i] <= cand_x;
          slot_y[i] <= cand_y;
        end
        // Only live slots can match, so the slot being spawned never collides with set_valid.
        if (check_collision && hit_any && (hit_idx == 3'(i)))
          valid_q[i] <= 1'b0;
        else if (set_valid && (tgt_q == 3'(i)))
          valid_q[i] <= 1'b1;
`ifdef FOOD_ERASE_EN
        if (check_collision && hit_any && (hit_idx == 3'(i)))
          erase_pend[i] <= 1'b1;
        else if (erase_done && (tgt_q == 3'(i)))
          erase_pend[i] <= 1'b0;
`endif
      end
    end
  end

  // Flatten slots onto the output buses and select the coordinate being drawn.
  always_comb begin
    plot_x = '0;
    plot_y = '0;
    for (int i = 0; i < NUM_FOOD; i++) begin
      food_x[i*X_W +: X_W] = slot_x[i];
      food_y[i*Y_W +: Y_W] = slot_y[i];
      if (plot_req && (tgt_q == 3'(i))) begin
        plot_x = slot_x[i];
        plot_y = slot_y[i];
      end
    end
  end

  assign food_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
